tm1640_rx: RTL and testbench
============================

// Module: tm1640_rx
// PURPOSE
// Receive-side model of the TM1640 2-wire display link. Samples tm_clk/tm_din, detects START/STOP,
// deserialises LSB-first bytes and decodes data/address/display-control commands into a 16x8
// display RAM plus control state. Used as a bench monitor for the tm1640 transmitter and as a
// display emulator on boards without the physical chip.
// PARAMETERS
// SYNC_STAGES  2   flops in the input synchronisers (>=2)
// PORTS
// clk         in   1  system clock
// rst         in   1  synchronous, active-high reset
// tm_clk      in   1  TM1640 serial clock (async)
// tm_din      in   1  TM1640 serial data (async)
// byte_valid  out  1  1-cycle pulse, byte_data holds a completed byte
// byte_data   out  8  last received byte
// frame_start out  1  1-cycle pulse on START
// frame_stop  out  1  1-cycle pulse on STOP
// frame_err   out  1  1-cycle pulse: STOP/re-START with partial byte (bit_cnt!=0)
// cmd_err     out  1  1-cycle pulse: first byte of frame has [7:6]=00
// ram_we      out  1  1-cycle pulse, display RAM write
// ram_waddr   out  4  write address
// ram_wdata   out  8  write data
// rd_addr     in   4  RAM readback address
// rd_data     out  8  ram[rd_addr], combinational
// disp_on     out  1  display-control bit 3
// brightness  out  3  display-control bits [2:0]
// fixed_addr  out  1  data-command bit 2 (1 = no address increment)
// BEHAVIOUR
// - Reset: all outputs/pulses 0, RAM all 0x00, addr 0, bit_cnt 0, state IDLE.
// - Inputs pass SYNC_STAGES flops + 1 history flop; events seen SYNC_STAGES+1 cycles after pins.
//   Each tm_clk level must last >= SYNC_STAGES+2 clk cycles; faster input is out of spec.
// - START: din_s 1->0 with clk_s high in both previous and current sample. STOP: din_s 0->1, same
//   condition. clk_s edge in same cycle as din_s change => clock edge only, no START/STOP.
// - Bit: clk_s rising edge in FIRST/DATA/WAIT_STOP: shreg <= {din_s, shreg[7:1]}, bit_cnt++.
//   8th bit: byte_valid=1, byte_data=byte, bit_cnt=0, decode same cycle. Bits in IDLE ignored.
// - FSM: IDLE -START-> FIRST. In FIRST on byte:
//   [7:6]=01 data cmd: fixed_addr<=b[2]; ->WAIT_STOP
//   [7:6]=11 addr cmd: addr<=b[3:0]; ->DATA
//   [7:6]=10 ctrl cmd: disp_on<=b[3], brightness<=b[2:0]; ->WAIT_STOP
//   [7:6]=00 cmd_err pulse; ->WAIT_STOP
//   DATA on byte: ram[addr]<=byte, ram_we pulse (waddr=addr, wdata=byte); if !fixed_addr
//   addr<=addr+1 mod 16 (15 wraps to 0). WAIT_STOP: extra bytes pulse byte_valid only.
// - STOP in any non-IDLE state -> IDLE, frame_stop; frame_err too if bit_cnt!=0.
//   START while not IDLE = re-start: frame_err if bit_cnt!=0, bit_cnt=0, ->FIRST, frame_start.
//   STOP in IDLE: frame_stop pulse only.
// - RAM write and rd_addr read of same entry same cycle: rd_data shows old value.
// - rst mid-frame: immediate return to reset state; link resyncs at next START.
// STRUCTURE
// - tm1640_defs.vh: CMD_DATA=2'b01, CMD_ADDR=2'b11, CMD_CTRL=2'b10, state encodings,
//   shared with the tm1640 transmitter.
// - One sub-module tm1640_rx_phy: synchronisers, edge detect, START/STOP, shift register,
//   bit_cnt, byte_valid. Top holds FSM, command decode, RAM.
// TESTING (bench drives pins with a behavioural TM1640 master, tm_clk >= 8 clk per phase)
// - Frames 42 | C0 06 5B 4F 66 6D 7C 07 7F 6F | 8F -> ram[0..8]=06,5B,4F,66,6D,7C,07,7F,6F;
//   ram[9..15]=00; disp_on=1, brightness=7, fixed_addr=0; 12 byte_valid, 9 ram_we.
// - Frames 44 | C5 A1 B2 -> ram[5]=B2 only, two ram_we both waddr=5, fixed_addr=1.
// - Frames 40 | CF 11 22 -> ram[15]=11, ram[0]=22 (wrap).
// - START, 5 bits, STOP -> frame_err=1, no byte_valid, RAM unchanged; next frame 8A ->
//   disp_on=1, brightness=2.
// - Frame 00 -> cmd_err pulse, no state change; START+3 bits then START again -> frame_err,
//   following C3 7F -> ram[3]=7F.
// - rst asserted after 4 data bytes of an addr frame -> RAM all 00, outputs 0; next full frame OK.

Source files
------------

// File: rtl/tm1640_rx_pkg.sv
// Shared definitions for the TM1640 receive path: command codes, FSM states
// and a helper that extracts the command class from the first frame byte.
// Command codes match those used by the tm1640 transmitter.
package tm1640_rx_pkg;

  // Command class lives in bits [7:6] of the first byte of a frame.
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_ADDR = 2'b11;
  localparam logic [1:0] CMD_CTRL = 2'b10;

  localparam int BIT_CNT_W = 3;  // counts 0..7 bits within a byte
  localparam int RAM_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FIRST     = 2'd1,
    ST_DATA      = 2'd2,
    ST_WAIT_STOP = 2'd3
  } rx_state_e;

  function automatic logic [1:0] cmd_type(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/tm1640_rx_phy.sv
// Link layer of the TM1640 receiver: synchronises tm_clk/tm_din, detects
// START/STOP, shifts in LSB-first bits and flags completed bytes.
// Ports: clk/rst; tm_clk/tm_din async pins; bit_en (frame open) from the FSM;
// registered 1-cycle pulses byte_valid/frame_start/frame_stop/frame_err;
// byte_data holds the last completed byte.
module tm1640_rx_phy
  import tm1640_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tm_clk,
  input  logic       tm_din,
  input  logic       bit_en,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_start,
  output logic       frame_stop,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   clk_h_q, clk_h_d;
  logic                   din_h_q, din_h_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   byte_valid_q, byte_valid_d;
  logic [7:0]             byte_data_q, byte_data_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_stop_q, frame_stop_d;
  logic                   frame_err_q, frame_err_d;

  logic clk_s, din_s, clk_rise, start_det, stop_det;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];

  // START/STOP need clk high in both samples, so a data change landing in
  // the same cycle as a clock edge is treated as the clock edge only.
  assign clk_rise  = clk_s & ~clk_h_q;
  assign start_det = clk_s & clk_h_q & din_h_q & ~din_s;
  assign stop_det  = clk_s & clk_h_q & ~din_h_q & din_s;

  always_comb begin
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], tm_clk};
    din_sync_d    = {din_sync_q[SYNC_STAGES-2:0], tm_din};
    clk_h_d       = clk_s;
    din_h_d       = din_s;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    frame_start_d = start_det;
    frame_stop_d  = stop_det;
    frame_err_d   = (start_det | stop_det) & (bit_cnt_q != '0);
    if (start_det || stop_det) begin
      bit_cnt_d = '0;
    end else if (clk_rise && bit_en) begin
      shreg_d   = {din_s, shreg_q[7:1]};
      bit_cnt_d = bit_cnt_q + 1'b1;  // wraps to 0 after the 8th bit
      if (bit_cnt_q == '1) begin
        byte_valid_d = 1'b1;
        byte_data_d  = shreg_d;
      end
    end
  end

  // Synchronisers reset low: both pins then rise together, so a high idle
  // bus after reset never looks like a STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q    <= '0;
      din_sync_q    <= '0;
      clk_h_q       <= 1'b0;
      din_h_q       <= 1'b0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= '0;
      frame_start_q <= 1'b0;
      frame_stop_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      din_sync_q    <= din_sync_d;
      clk_h_q       <= clk_h_d;
      din_h_q       <= din_h_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      frame_start_q <= frame_start_d;
      frame_stop_q  <= frame_stop_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign frame_start = frame_start_q;
  assign frame_stop  = frame_stop_q;
  assign frame_err   = frame_err_q;

endmodule

// File: rtl/tm1640_rx.sv
// TM1640 receiver/display emulator: frame FSM, command decode, 16x8 RAM.
// Ports: clk/rst; tm_clk/tm_din pins; byte/frame event pulses; ram_we/waddr/
// wdata write strobe; rd_addr -> rd_data combinational readback; control state.
module tm1640_rx
  import tm1640_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tm_clk,
  input  logic       tm_din,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_start,
  output logic       frame_stop,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       ram_we,
  output logic [3:0] ram_waddr,
  output logic [7:0] ram_wdata,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       disp_on,
  output logic [2:0] brightness,
  output logic       fixed_addr
);

  rx_state_e  state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic       fixed_addr_q, fixed_addr_d;
  logic       disp_on_q, disp_on_d;
  logic [2:0] brightness_q, brightness_d;
  logic [7:0] ram_q [RAM_DEPTH];
  logic [7:0] ram_d [RAM_DEPTH];

  tm1640_rx_phy #(.SYNC_STAGES(SYNC_STAGES)) u_phy (
    .clk         (clk),
    .rst         (rst),
    .tm_clk      (tm_clk),
    .tm_din      (tm_din),
    .bit_en      (state_q != ST_IDLE),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_start (frame_start),
    .frame_stop  (frame_stop),
    .frame_err   (frame_err)
  );

  // Decode acts in the cycle byte_valid is high; write strobe and cmd_err
  // are combinational from registered state so they line up with it.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fixed_addr_d = fixed_addr_q;
    disp_on_d    = disp_on_q;
    brightness_d = brightness_q;
    ram_d        = ram_q;
    ram_we       = 1'b0;
    ram_waddr    = addr_q;
    ram_wdata    = byte_data;
    cmd_err      = 1'b0;
    if (frame_start) begin
      state_d = ST_FIRST;  // also covers re-START inside a frame
    end else if (frame_stop) begin
      state_d = ST_IDLE;
    end else if (byte_valid) begin
      case (state_q)
        ST_FIRST: begin
          case (cmd_type(byte_data))
            CMD_DATA: begin
              fixed_addr_d = byte_data[2];
              state_d      = ST_WAIT_STOP;
            end
            CMD_ADDR: begin
              addr_d  = byte_data[3:0];
              state_d = ST_DATA;
            end
            CMD_CTRL: begin
              disp_on_d    = byte_data[3];
              brightness_d = byte_data[2:0];
              state_d      = ST_WAIT_STOP;
            end
            default: begin
              cmd_err = 1'b1;
              state_d = ST_WAIT_STOP;
            end
          endcase
        end
        ST_DATA: begin
          ram_we         = 1'b1;
          ram_d[addr_q]  = byte_data;
          if (!fixed_addr_q) addr_d = addr_q + 4'd1;  // 15 wraps to 0
        end
        default: ;  // WAIT_STOP: byte is reported but not decoded
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      fixed_addr_q <= 1'b0;
      disp_on_q    <= 1'b0;
      brightness_q <= '0;
      ram_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fixed_addr_q <= fixed_addr_d;
      disp_on_q    <= disp_on_d;
      brightness_q <= brightness_d;
      ram_q        <= ram_d;
    end
  end

  // Reads the registered array, so a same-cycle write shows the old value.
  assign rd_data    = ram_q[rd_addr];
  assign disp_on    = disp_on_q;
  assign brightness = brightness_q;
  assign fixed_addr = fixed_addr_q;

endmodule

// File: tb/tb_tm1640_rx.sv
// Bench for tm1640_rx: behavioural TM1640 master drives the pins, a monitor
// scoreboards byte_valid / ram_we against queued expectations, and directed
// checks read back RAM and control state after each scenario.
module tb_tm1640_rx;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tm_clk  = 1'b1;
  logic       tm_din  = 1'b1;
  logic [3:0] rd_addr = '0;

  logic       byte_valid, frame_start, frame_stop, frame_err, cmd_err, ram_we;
  logic [7:0] byte_data, ram_wdata, rd_data;
  logic [3:0] ram_waddr;
  logic       disp_on, fixed_addr;
  logic [2:0] brightness;

  tm1640_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tm_clk(tm_clk), .tm_din(tm_din),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_start(frame_start), .frame_stop(frame_stop),
    .frame_err(frame_err), .cmd_err(cmd_err),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .disp_on(disp_on), .brightness(brightness), .fixed_addr(fixed_addr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_bv = 0, n_we = 0, n_cmd_err = 0, n_ferr = 0, n_start = 0, n_stop = 0;
  int exp_ferr = 0, exp_start = 0, exp_stop = 0;
  int m_bits = 0;
  bit m_in_frame = 1'b0;
  int b0, w0, e0;

  logic [7:0]  exp_bytes [$];
  logic [11:0] exp_we [$];
  logic [7:0]  exp_ram [16];
  logic [7:0]  fb [$];
  logic [7:0]  mon_b;
  logic [11:0] mon_w;
  logic [7:0]  seg [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (byte_valid) begin
      n_bv++;
      if (exp_bytes.size() == 0) begin
        checks++; errors++;
        $display("FAIL byte_valid unexpected: got %02h, none expected", byte_data);
      end else begin
        mon_b = exp_bytes.pop_front();
        chk("byte_data", 32'(byte_data), 32'(mon_b));
      end
    end
    if (ram_we) begin
      n_we++;
      if (exp_we.size() == 0) begin
        checks++; errors++;
        $display("FAIL ram_we unexpected: got addr %0h data %02h, none expected", ram_waddr, ram_wdata);
      end else begin
        mon_w = exp_we.pop_front();
        chk("ram_we addr/data", 32'({ram_waddr, ram_wdata}), 32'(mon_w));
      end
    end
    if (cmd_err)     n_cmd_err++;
    if (frame_err)   n_ferr++;
    if (frame_start) n_start++;
    if (frame_stop)  n_stop++;
  end

  // One tm_clk phase = 10 clk cycles.
  task automatic half();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic m_rise();
    tm_clk = 1'b1;
    half();
    if (m_in_frame) m_bits++;
  endtask

  task automatic send_bit(input logic b);
    tm_clk = 1'b0; half();
    tm_din = b;    half();
    m_rise();
  endtask

  // A START needs clk high and din high first; getting there from clk high /
  // din low costs an extra rising clock edge.
  task automatic start_cond();
    if (!(tm_clk && tm_din)) begin
      if (tm_clk) begin tm_clk = 1'b0; half(); end
      tm_din = 1'b1; half();
      m_rise();
    end
    if (m_in_frame && (m_bits % 8 != 0)) exp_ferr++;
    tm_din = 1'b0; half();
    exp_start++; m_in_frame = 1'b1; m_bits = 0;
  endtask

  task automatic stop_cond();
    if (!(tm_clk && !tm_din)) begin
      if (tm_clk) begin tm_clk = 1'b0; half(); end
      tm_din = 1'b0; half();
      m_rise();
    end
    if (m_in_frame && (m_bits % 8 != 0)) exp_ferr++;
    tm_din = 1'b1; half();
    exp_stop++; m_in_frame = 1'b0; m_bits = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic frame();
    start_cond();
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i]);
    stop_cond();
  endtask

  task automatic push_we(input logic [3:0] a, input logic [7:0] d);
    exp_we.push_back({a, d});
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk($sformatf("%s ram[%0d]", tag, i), 32'(rd_data), 32'(exp_ram[i]));
    end
  endtask

  task automatic check_ctrl(input string tag, input logic on, input logic [2:0] br, input logic fx);
    chk({tag, " disp_on"}, 32'(disp_on), 32'(on));
    chk({tag, " brightness"}, 32'(brightness), 32'(br));
    chk({tag, " fixed_addr"}, 32'(fixed_addr), 32'(fx));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " pulses"}, 32'({byte_valid, frame_start, frame_stop, frame_err, cmd_err, ram_we}), 32'(0));
    chk({tag, " byte_data"}, 32'(byte_data), 32'(0));
    check_ctrl(tag, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    seg = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7C, 8'h07, 8'h7F, 8'h6F};
    for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_ram("reset");
    rst = 1'b0;
    half();

    // Auto-increment write of nine digits plus display control
    b0 = n_bv; w0 = n_we;
    fb = '{8'h42}; frame();
    fb = '{8'hC0};
    for (int i = 0; i < 9; i++) begin
      fb.push_back(seg[i]);
      push_we(4'(i), seg[i]);
      exp_ram[i] = seg[i];
    end
    frame();
    fb = '{8'h8F}; frame();
    half();
    chk("s1 byte_valid count", 32'(n_bv - b0), 32'd12);
    chk("s1 ram_we count", 32'(n_we - w0), 32'd9);
    check_ram("s1");
    check_ctrl("s1", 1'b1, 3'd7, 1'b0);

    // Fixed address mode: both writes land on address 5
    fb = '{8'h44}; frame();
    check_ctrl("s2 after 44", 1'b1, 3'd7, 1'b1);
    push_we(4'd5, 8'hA1); push_we(4'd5, 8'hB2);
    fb = '{8'hC5, 8'hA1, 8'hB2}; frame();
    exp_ram[5] = 8'hB2;
    half();
    check_ram("s2");

    // Address wrap 15 -> 0
    fb = '{8'h40}; frame();
    push_we(4'd15, 8'h11); push_we(4'd0, 8'h22);
    fb = '{8'hCF, 8'h11, 8'h22}; frame();
    exp_ram[15] = 8'h11; exp_ram[0] = 8'h22;
    half();
    check_ram("s3");
    check_ctrl("s3", 1'b1, 3'd7, 1'b0);

    // Partial byte then STOP: frame error, no byte
    b0 = n_bv; e0 = n_ferr;
    start_cond();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    stop_cond();
    half();
    chk("s4 frame_err count", 32'(n_ferr - e0), 32'd1);
    chk("s4 no byte_valid", 32'(n_bv - b0), 32'd0);
    check_ram("s4");
    fb = '{8'h8A}; frame();
    half();
    check_ctrl("s4 ctrl", 1'b1, 3'd2, 1'b0);

    // Bad command, then re-START after three bits
    e0 = n_ferr;
    fb = '{8'h00}; frame();
    half();
    chk("s5 cmd_err count", 32'(n_cmd_err), 32'd1);
    check_ctrl("s5 after 00", 1'b1, 3'd2, 1'b0);
    start_cond();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    start_cond();
    push_we(4'd3, 8'h7F);
    send_byte(8'hC3); send_byte(8'h7F);
    stop_cond();
    exp_ram[3] = 8'h7F;
    half();
    chk("s5 frame_err count", 32'(n_ferr - e0), 32'd1);
    check_ram("s5");

    // Reset in the middle of an address frame
    start_cond();
    send_byte(8'hC0);
    push_we(4'd0, 8'h11); push_we(4'd1, 8'h22); push_we(4'd2, 8'h33); push_we(4'd3, 8'h44);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    exp_ram[0] = 8'h11; exp_ram[1] = 8'h22; exp_ram[2] = 8'h33; exp_ram[3] = 8'h44;
    half();
    check_ram("s6 pre-reset");
    @(posedge clk); #1;
    rst = 1'b1;
    m_in_frame = 1'b0; m_bits = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;
    check_idle_outputs("s6 reset");
    check_ram("s6 reset");
    rst = 1'b0;
    half();
    fb = '{8'h40}; frame();
    push_we(4'd2, 8'hAB); push_we(4'd3, 8'hCD);
    fb = '{8'hC2, 8'hAB, 8'hCD}; frame();
    fb = '{8'h8C}; frame();
    exp_ram[2] = 8'hAB; exp_ram[3] = 8'hCD;
    half();
    check_ram("s6 post");
    check_ctrl("s6 post", 1'b1, 3'd4, 1'b0);

    // Totals and drained scoreboards
    chk("frame_start total", 32'(n_start), 32'(exp_start));
    chk("frame_stop total", 32'(n_stop), 32'(exp_stop));
    chk("frame_err total", 32'(n_ferr), 32'(exp_ferr));
    chk("bytes pending", 32'(exp_bytes.size()), 32'd0);
    chk("writes pending", 32'(exp_we.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
